ex_stage_unit: RTL and testbench

// - Execute stage of the FemtoRV32 5-stage pipeline, directly upstream of the EX/MEM->MEM->WB path.
// - Consumes ID/EX fields and forwards operands from MEM/WB. Computes ALU result, pc+4, pc+imm,

---
 rtl/femto_pkg.sv | 49 ++++
 rtl/femto_alu.sv | 38 +++
 rtl/ex_stage_unit.sv | 175 +++++++++++++++++
 tb/tb_ex_stage_unit.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/femto_pkg.sv
// Shared constants and types for the FemtoRV32 execute stage.
package femto_pkg;

  localparam int XLEN = 32;
  localparam int REGA = 5;

  // ALU operation codes
  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLL   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_SLT   = 4'd8;
  localparam logic [3:0] ALU_SLTU  = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  // Writeback source selects
  localparam logic [1:0] AJ_ALU   = 2'b00;
  localparam logic [1:0] AJ_PC4   = 2'b01;
  localparam logic [1:0] AJ_PCIMM = 2'b10;

  // Branch conditions (funct3)
  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  // Contents of the EX/MEM pipeline register
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] pcimm;
    logic [2:0]      funct3;
    logic [REGA-1:0] rd;
    logic            regwrite;
    logic            memtoreg;
    logic            memread;
    logic            memwrite;
    logic [1:0]      aj_ctrl;
  } exmem_t;

endpackage

// File: rtl/femto_alu.sv
// Combinational integer ALU for the execute stage.
module femto_alu
  import femto_pkg::*;
(
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y
);

  logic [4:0] shamt_s;
  logic       lt_s;
  logic       ltu_s;

  assign shamt_s = b[4:0];
  assign lt_s    = ($signed(a) < $signed(b));
  assign ltu_s   = (a < b);

  // Select the result for the requested operation; unknown codes yield zero
  always_comb begin
    y = {XLEN{1'b0}};
    case (op)
      ALU_ADD:   y = a + b;
      ALU_SUB:   y = a - b;
      ALU_AND:   y = a & b;
      ALU_OR:    y = a | b;
      ALU_XOR:   y = a ^ b;
      ALU_SLL:   y = a << shamt_s;
      ALU_SRL:   y = a >> shamt_s;
      ALU_SRA:   y = $unsigned($signed(a) >>> shamt_s);
      ALU_SLT:   y = {{(XLEN-1){1'b0}}, lt_s};
      ALU_SLTU:  y = {{(XLEN-1){1'b0}}, ltu_s};
      ALU_PASSB: y = b;
      default:   y = {XLEN{1'b0}};
    endcase
  end

endmodule

// File: rtl/ex_stage_unit.sv
// Execute stage: operand forwarding, ALU, branch/jump resolution,
// load-use detection and the EX/MEM pipeline register.
module ex_stage_unit
  import femto_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [31:0]     id_rd1,
  input  logic [31:0]     id_rd2,
  input  logic [31:0]     id_imm,
  input  logic [31:0]     id_pc,
  input  logic [3:0]      id_alu_op,
  input  logic            id_alusrc,
  input  logic [2:0]      id_funct3,
  input  logic [4:0]      id_rd,
  input  logic            id_regwrite,
  input  logic            id_memtoreg,
  input  logic            id_memread,
  input  logic            id_memwrite,
  input  logic            id_branch,
  input  logic            id_jalr,
  input  logic            id_jal,
  input  logic [1:0]      id_aj_ctrl,
  input  logic [4:0]      dec_rs1,
  input  logic [4:0]      dec_rs2,
  input  logic [4:0]      mem_rd,
  input  logic [4:0]      wb_rd,
  input  logic            mem_regwrite,
  input  logic            wb_regwrite,
  input  logic [31:0]     mem_fwd_data,
  input  logic [31:0]     wb_fwd_data,
  output logic            redirect,
  output logic [31:0]     redirect_pc,
  output logic            load_use,
  output logic            exmem_valid,
  output logic [31:0]     exmem_alu,
  output logic [31:0]     exmem_rs2,
  output logic [31:0]     exmem_pc4,
  output logic [31:0]     exmem_pcimm,
  output logic [2:0]      exmem_funct3,
  output logic [4:0]      exmem_rd,
  output logic            exmem_regwrite,
  output logic            exmem_memtoreg,
  output logic            exmem_memread,
  output logic            exmem_memwrite,
  output logic [1:0]      exmem_aj_ctrl
);

  logic [XLEN-1:0] fwd_rs1_s;
  logic [XLEN-1:0] fwd_rs2_s;
  logic [XLEN-1:0] op_b_s;
  logic [XLEN-1:0] alu_y_s;
  logic [XLEN-1:0] pc4_s;
  logic [XLEN-1:0] pcimm_s;
  logic [XLEN-1:0] jalr_sum_s;
  logic            cond_s;
  exmem_t          exmem_next_s;
  exmem_t          exmem_r;

  // Operand A forwarding: MEM result is newer than WB, so it takes priority
  always_comb begin
    fwd_rs1_s = id_rd1;
    if (mem_regwrite && (mem_rd != 5'd0) && (mem_rd == id_rs1)) begin
      fwd_rs1_s = mem_fwd_data;
    end else if (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == id_rs1)) begin
      fwd_rs1_s = wb_fwd_data;
    end else begin
      fwd_rs1_s = id_rd1;
    end
  end

  // Operand B forwarding, same priority as operand A
  always_comb begin
    fwd_rs2_s = id_rd2;
    if (mem_regwrite && (mem_rd != 5'd0) && (mem_rd == id_rs2)) begin
      fwd_rs2_s = mem_fwd_data;
    end else if (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == id_rs2)) begin
      fwd_rs2_s = wb_fwd_data;
    end else begin
      fwd_rs2_s = id_rd2;
    end
  end

  assign op_b_s     = id_alusrc ? id_imm : fwd_rs2_s;
  assign pc4_s      = id_pc + 32'd4;
  assign pcimm_s    = id_pc + id_imm;
  assign jalr_sum_s = fwd_rs1_s + id_imm;

  femto_alu u_alu (
    .op (id_alu_op),
    .a  (fwd_rs1_s),
    .b  (op_b_s),
    .y  (alu_y_s)
  );

  // Branch condition evaluated on the forwarded register operands
  always_comb begin
    cond_s = 1'b0;
    case (id_funct3)
      BR_EQ:   cond_s = (fwd_rs1_s == fwd_rs2_s);
      BR_NE:   cond_s = (fwd_rs1_s != fwd_rs2_s);
      BR_LT:   cond_s = ($signed(fwd_rs1_s) < $signed(fwd_rs2_s));
      BR_GE:   cond_s = ($signed(fwd_rs1_s) >= $signed(fwd_rs2_s));
      BR_LTU:  cond_s = (fwd_rs1_s < fwd_rs2_s);
      BR_GEU:  cond_s = (fwd_rs1_s >= fwd_rs2_s);
      default: cond_s = 1'b0;
    endcase
  end

  // Control-flow redirect and target; JALR clears bit 0 of the target
  always_comb begin
    redirect    = id_valid & (id_jal | id_jalr | (id_branch & cond_s));
    redirect_pc = pcimm_s;
    if (id_jalr) begin
      redirect_pc = {jalr_sum_s[XLEN-1:1], 1'b0};
    end else begin
      redirect_pc = pcimm_s;
    end
  end

  // Load-use hazard: the load in EX produces a register decode needs now
  always_comb begin
    load_use = id_valid & id_memread & (id_rd != 5'd0) &
               ((id_rd == dec_rs1) | (id_rd == dec_rs2));
  end

  // Next EX/MEM contents; control bits are qualified so bubbles never write
  always_comb begin
    exmem_next_s          = '0;
    exmem_next_s.valid    = id_valid;
    exmem_next_s.alu      = alu_y_s;
    exmem_next_s.rs2      = fwd_rs2_s;
    exmem_next_s.pc4      = pc4_s;
    exmem_next_s.pcimm    = pcimm_s;
    exmem_next_s.funct3   = id_funct3;
    exmem_next_s.rd       = id_rd;
    exmem_next_s.regwrite = id_regwrite & id_valid;
    exmem_next_s.memtoreg = id_memtoreg & id_valid;
    exmem_next_s.memread  = id_memread  & id_valid;
    exmem_next_s.memwrite = id_memwrite & id_valid;
    exmem_next_s.aj_ctrl  = id_aj_ctrl & {2{id_valid}};
  end

  // EX/MEM register: async clear, flush loads a bubble and beats stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exmem_r <= '0;
    end else if (flush) begin
      exmem_r <= '0;
    end else if (!stall) begin
      exmem_r <= exmem_next_s;
    end else begin
      exmem_r <= exmem_r;
    end
  end

  assign exmem_valid    = exmem_r.valid;
  assign exmem_alu      = exmem_r.alu;
  assign exmem_rs2      = exmem_r.rs2;
  assign exmem_pc4      = exmem_r.pc4;
  assign exmem_pcimm    = exmem_r.pcimm;
  assign exmem_funct3   = exmem_r.funct3;
  assign exmem_rd       = exmem_r.rd;
  assign exmem_regwrite = exmem_r.regwrite;
  assign exmem_memtoreg = exmem_r.memtoreg;
  assign exmem_memread  = exmem_r.memread;
  assign exmem_memwrite = exmem_r.memwrite;
  assign exmem_aj_ctrl  = exmem_r.aj_ctrl;

endmodule

// File: tb/tb_ex_stage_unit.sv
// Scoreboard bench for ex_stage_unit: a behavioural model predicts the
// EX/MEM contents per cycle into a queue that a monitor drains.
module tb_ex_stage_unit;
  import femto_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, stall, flush, id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd, dec_rs1, dec_rs2, mem_rd, wb_rd;
  logic [31:0] id_rd1, id_rd2, id_imm, id_pc, mem_fwd_data, wb_fwd_data;
  logic [3:0] id_alu_op;
  logic id_alusrc, id_regwrite, id_memtoreg, id_memread, id_memwrite;
  logic id_branch, id_jalr, id_jal, mem_regwrite, wb_regwrite;
  logic [2:0] id_funct3;
  logic [1:0] id_aj_ctrl;
  logic redirect, load_use;
  logic [31:0] redirect_pc;
  logic exmem_valid, exmem_regwrite, exmem_memtoreg, exmem_memread, exmem_memwrite;
  logic [31:0] exmem_alu, exmem_rs2, exmem_pc4, exmem_pcimm;
  logic [2:0] exmem_funct3;
  logic [4:0] exmem_rd;
  logic [1:0] exmem_aj_ctrl;

  ex_stage_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd1(id_rd1), .id_rd2(id_rd2),
    .id_imm(id_imm), .id_pc(id_pc), .id_alu_op(id_alu_op), .id_alusrc(id_alusrc),
    .id_funct3(id_funct3), .id_rd(id_rd), .id_regwrite(id_regwrite),
    .id_memtoreg(id_memtoreg), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .id_branch(id_branch), .id_jalr(id_jalr), .id_jal(id_jal), .id_aj_ctrl(id_aj_ctrl),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
    .mem_fwd_data(mem_fwd_data), .wb_fwd_data(wb_fwd_data),
    .redirect(redirect), .redirect_pc(redirect_pc), .load_use(load_use),
    .exmem_valid(exmem_valid), .exmem_alu(exmem_alu), .exmem_rs2(exmem_rs2),
    .exmem_pc4(exmem_pc4), .exmem_pcimm(exmem_pcimm), .exmem_funct3(exmem_funct3),
    .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite), .exmem_memtoreg(exmem_memtoreg),
    .exmem_memread(exmem_memread), .exmem_memwrite(exmem_memwrite),
    .exmem_aj_ctrl(exmem_aj_ctrl)
  );

  typedef struct packed {
    logic        valid;
    logic [31:0] alu, rs2, pc4, pcimm;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        rw, m2r, mr, mw;
    logic [1:0]  aj;
  } exm_t;

  exm_t exp_q[$];
  exm_t model_r;
  int checks = 0;
  int passed = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  // Register value seen by EX after MEM/WB bypass
  function automatic logic [31:0] src_val(logic [4:0] rs, logic [31:0] rf);
    if (mem_regwrite && mem_rd != 5'd0 && mem_rd == rs) return mem_fwd_data;
    if (wb_regwrite && wb_rd != 5'd0 && wb_rd == rs) return wb_fwd_data;
    return rf;
  endfunction

  function automatic logic [31:0] ref_alu(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    int sh;
    longint sa;
    sh = int'(b % 32);
    sa = longint'($signed(a));
    case (op)
      ALU_ADD:   return 32'(longint'(a) + longint'(b));
      ALU_SUB:   return 32'(longint'(a) - longint'(b));
      ALU_AND:   return a & b;
      ALU_OR:    return a | b;
      ALU_XOR:   return a ^ b;
      ALU_SLL:   return 32'(longint'(a) * (64'd1 << sh));
      ALU_SRL:   return 32'(longint'(a) / (64'd1 << sh));
      ALU_SRA:   return 32'(sa >>> sh);
      ALU_SLT:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU:  return (a < b) ? 32'd1 : 32'd0;
      ALU_PASSB: return b;
      default:   return 32'd0;
    endcase
  endfunction

  function automatic logic taken(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return sa < sb;
      3'b101:  return sa >= sb;
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // One cycle: predict, check combinational outputs, queue EX/MEM prediction
  task automatic step();
    logic [31:0] a, b, ob, tgt;
    logic red, lu;
    exm_t n;
    a  = src_val(id_rs1, id_rd1);
    b  = src_val(id_rs2, id_rd2);
    ob = id_alusrc ? id_imm : b;
    red = id_valid && (id_jal || id_jalr || (id_branch && taken(id_funct3, a, b)));
    tgt = id_jalr ? ((a + id_imm) & 32'hFFFF_FFFE) : (id_pc + id_imm);
    lu  = id_valid && id_memread && id_rd != 5'd0 && (id_rd == dec_rs1 || id_rd == dec_rs2);
    #1;
    chk("redirect", 32'(redirect), 32'(red));
    chk("redirect_pc", redirect_pc, tgt);
    chk("load_use", 32'(load_use), 32'(lu));
    if (flush) n = '0;
    else if (stall) n = model_r;
    else begin
      n.valid = id_valid;
      n.alu = ref_alu(id_alu_op, a, ob);
      n.rs2 = b;
      n.pc4 = id_pc + 32'd4;
      n.pcimm = id_pc + id_imm;
      n.f3 = id_funct3;
      n.rd = id_rd;
      n.rw = id_valid & id_regwrite;
      n.m2r = id_valid & id_memtoreg;
      n.mr = id_valid & id_memread;
      n.mw = id_valid & id_memwrite;
      n.aj = id_valid ? id_aj_ctrl : 2'b00;
    end
    model_r = n;
    exp_q.push_back(n);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    stall = 1'b0; flush = 1'b0; id_valid = 1'b1;
    id_rs1 = 5'd1; id_rs2 = 5'd2; id_rd1 = 32'd0; id_rd2 = 32'd0;
    id_imm = 32'd0; id_pc = 32'd0; id_alu_op = ALU_ADD; id_alusrc = 1'b0;
    id_funct3 = 3'b010; id_rd = 5'd0; id_regwrite = 1'b0; id_memtoreg = 1'b0;
    id_memread = 1'b0; id_memwrite = 1'b0; id_branch = 1'b0; id_jalr = 1'b0;
    id_jal = 1'b0; id_aj_ctrl = 2'b00; dec_rs1 = 5'd0; dec_rs2 = 5'd0;
    mem_rd = 5'd0; wb_rd = 5'd0; mem_regwrite = 1'b0; wb_regwrite = 1'b0;
    mem_fwd_data = 32'd0; wb_fwd_data = 32'd0;
  endtask

  task automatic rand_inputs();
    stall = ($urandom_range(7, 0) == 0);
    flush = ($urandom_range(9, 0) == 0);
    id_valid = ($urandom_range(5, 0) != 0);
    id_rs1 = 5'($urandom_range(3, 0)); id_rs2 = 5'($urandom_range(3, 0));
    id_rd1 = $urandom; id_rd2 = $urandom;
    id_imm = ($urandom_range(1, 0) == 1) ? $urandom : 32'($urandom_range(40, 0));
    id_pc = $urandom & 32'hFFFF_FFFC;
    id_alu_op = 4'($urandom_range(10, 0)); id_alusrc = 1'($urandom);
    id_funct3 = 3'($urandom); id_rd = 5'($urandom_range(3, 0));
    id_regwrite = 1'($urandom); id_memtoreg = 1'($urandom);
    id_memread = 1'($urandom); id_memwrite = 1'($urandom);
    id_branch = 1'($urandom); id_jalr = ($urandom_range(3, 0) == 0);
    id_jal = ($urandom_range(3, 0) == 0); id_aj_ctrl = 2'($urandom_range(2, 0));
    dec_rs1 = 5'($urandom_range(3, 0)); dec_rs2 = 5'($urandom_range(3, 0));
    mem_rd = 5'($urandom_range(3, 0)); wb_rd = 5'($urandom_range(3, 0));
    mem_regwrite = 1'($urandom); wb_regwrite = 1'($urandom);
    mem_fwd_data = $urandom; wb_fwd_data = $urandom;
    if ($urandom_range(3, 0) == 0) id_rd2 = id_rd1;
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_valid"}, 32'(exmem_valid), 32'd0);
    chk({tag, "_alu"}, exmem_alu, 32'd0);
    chk({tag, "_ctrl"}, 32'({exmem_regwrite, exmem_memtoreg, exmem_memread,
                             exmem_memwrite, exmem_aj_ctrl}), 32'd0);
    chk({tag, "_data"}, exmem_rs2 | exmem_pc4 | exmem_pcimm |
        32'({exmem_funct3, exmem_rd}), 32'd0);
  endtask

  // Monitor: compare registered outputs against the queued prediction
  initial begin
    exm_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("exm_valid", 32'(exmem_valid), 32'(e.valid));
        chk("exm_alu", exmem_alu, e.alu);
        chk("exm_rs2", exmem_rs2, e.rs2);
        chk("exm_pc4", exmem_pc4, e.pc4);
        chk("exm_pcimm", exmem_pcimm, e.pcimm);
        chk("exm_f3_rd", 32'({exmem_funct3, exmem_rd}), 32'({e.f3, e.rd}));
        chk("exm_ctrl", 32'({exmem_regwrite, exmem_memtoreg, exmem_memread, exmem_memwrite, exmem_aj_ctrl}),
            32'({e.rw, e.m2r, e.mr, e.mw, e.aj}));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with garbage on every input
    rst = 1'b1;
    rand_inputs();
    @(negedge clk); #1;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    model_r = '0;
    clear_inputs();

    // ADD 5 + 7
    id_rd1 = 32'd5; id_rd2 = 32'd7; id_rd = 5'd4; id_regwrite = 1'b1;
    step();
    chk("add_5_7", exmem_alu, 32'd12);

    // Forwarding priority MEM over WB, then WB alone
    clear_inputs();
    id_rs1 = 5'd3; id_alusrc = 1'b1; id_imm = 32'd0; id_rd1 = 32'h11;
    mem_regwrite = 1'b1; mem_rd = 5'd3; mem_fwd_data = 32'hAA;
    wb_regwrite = 1'b1; wb_rd = 5'd3; wb_fwd_data = 32'hBB;
    step();
    chk("fwd_mem", exmem_alu, 32'hAA);
    mem_rd = 5'd0;
    step();
    chk("fwd_wb", exmem_alu, 32'hBB);

    // BLT taken on signed compare, BLTU not taken
    clear_inputs();
    id_branch = 1'b1; id_funct3 = BR_LT; id_rd1 = 32'hFFFF_FFFF; id_rd2 = 32'd1;
    id_pc = 32'h100; id_imm = 32'h20;
    #1;
    chk("blt_redirect", 32'(redirect), 32'd1);
    chk("blt_target", redirect_pc, 32'h120);
    step();
    id_funct3 = BR_LTU;
    #1;
    chk("bltu_redirect", 32'(redirect), 32'd0);
    step();

    // JALR target with bit 0 cleared, link address pc+4
    clear_inputs();
    id_jalr = 1'b1; id_rd1 = 32'h203; id_imm = 32'h10; id_aj_ctrl = AJ_PC4;
    id_pc = 32'h40; id_rd = 5'd1; id_regwrite = 1'b1;
    #1;
    chk("jalr_target", redirect_pc, 32'h212);
    step();
    chk("jalr_pc4", exmem_pc4, 32'h44);

    // Load-use hazard
    clear_inputs();
    id_memread = 1'b1; id_rd = 5'd5; dec_rs2 = 5'd5;
    #1;
    chk("load_use_hit", 32'(load_use), 32'd1);
    step();
    id_rd = 5'd0;
    #1;
    chk("load_use_x0", 32'(load_use), 32'd0);
    step();

    // Stall holds for two cycles, then stall+flush clears
    clear_inputs();
    id_rd1 = 32'd100; id_rd2 = 32'd23; id_alu_op = ALU_SUB; id_rd = 5'd7;
    id_regwrite = 1'b1; id_memwrite = 1'b1;
    step();
    stall = 1'b1; id_rd1 = 32'd9; id_rd = 5'd9;
    step();
    step();
    chk("stall_hold", exmem_alu, 32'd77);
    flush = 1'b1;
    step();
    chk("flush_valid", 32'(exmem_valid), 32'd0);
    chk("flush_ctrl", 32'({exmem_regwrite, exmem_memwrite}), 32'd0);

    // Randomized traffic with one asynchronous reset in the middle
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        #2 rst = 1'b1;
        #1 check_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        model_r = '0;
      end
      rand_inputs();
      step();
    end

    @(negedge clk);
    chk("queue_drain", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
